c_bus_demux: RTL and testbench
==============================

# c_bus_demux

Write-back demultiplexer for the processor's C bus: the write-side counterpart of the A-bus source select. It captures a 16-bit result from the C bus together with a 5-bit destination code, chosen from RG1, RG2 or the MUX1D field. It then drives one cycle of one-hot load enable into the selected register (R1..R14, TOTR, AR, MDDR, AC, MIDR) and acknowledges the requester. It sits between the ALU/memory result path and the register bank load inputs.

## Interface
- No parameters; widths are fixed by the package constants.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- C_BUS_in  in  16  result data to write.
- RG1_out  in  5  destination code from RG1.
- RG2_out  in  5  destination code from RG2.
- MUX1D_out  in  5  destination code from the microinstruction field.
- DEMUXS  in  2  code source: 0 none, 1 RG1, 2 MUX1D, 3 RG2.
- WR_REQ  in  1  single-cycle write request pulse.
- WR_DATA  out  16  registered data presented to the register bank.
- WR_EN  out  22  one-hot load enables, bit index = destination code.
- WR_ACK  out  1  one-cycle completion pulse.
- BUSY  out  1  high while a transaction is in flight.
- OVERRUN  out  1  sticky flag: a request was dropped.
- ILLEGAL  out  1  one-cycle pulse: the destination code was unmapped.

## Operation
- Destination codes:
  - 1..14 → R1..R14; 15 → TOTR; 18 → AR; 19 → MDDR; 20 → AC; 21 → MIDR.
  - Unmapped: 0, 16, 17, 22..31.
  - DEMUXS = 0 is treated as unmapped.
- WR_EN bits 0, 16, 17 are never asserted.
- FSM states: IDLE → DECODE → WRITE → ACK → IDLE.
- IDLE:
  - On WR_REQ = 1, latch C_BUS_in into WR_DATA.
  - Latch the code selected by DEMUXS into the internal code register.
  - Go to DECODE.
- DECODE: compute the one-hot vector and the legal flag into registers.
- WRITE: WR_EN = one-hot vector if legal, else all zero. WR_DATA stays stable.
- ACK: WR_ACK = 1; ILLEGAL = 1 if the code was unmapped (see Configuration). Return to IDLE.
- Source codes are sampled only at capture. Later changes to RG1/RG2/MUX1D/DEMUXS do not affect the transaction in flight.
- A WR_REQ in DECODE, WRITE or ACK is dropped, no write occurs for it, and OVERRUN sets. OVERRUN is cleared only by Reset.
- An unmapped code still runs the full sequence and still produces WR_ACK, with no write.

## Timing
- Reset values: state IDLE, WR_DATA 0, WR_EN 0, WR_ACK 0, BUSY 0, OVERRUN 0, ILLEGAL 0.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs zero. No WR_EN pulse or WR_ACK is issued for the aborted transaction.
- WR_REQ is sampled at edge 0.
  - BUSY = 1 from edge 0 through the end of the ACK cycle.
  - WR_EN is high for exactly the cycle after edge 2.
  - WR_ACK is high for the cycle after edge 3.
  - The register bank loads on edge 3.
- Back-to-back throughput: one write per 4 cycles. A WR_REQ in the first IDLE cycle after ACK is accepted.
- WR_REQ coincident with Reset deassertion: ignored on that edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- C_BUS_DEMUX_TRAP_EN defined: unmapped codes pulse ILLEGAL in the ACK cycle.
- C_BUS_DEMUX_TRAP_EN undefined: ILLEGAL is tied 0. Unmapped codes are silently acknowledged with no write. All other behaviour is identical.

## Structure
- Package cbus_pkg holds:
  - destination code constants CODE_R1..CODE_R14, CODE_TOTR, CODE_AR, CODE_MDDR, CODE_AC, CODE_MIDR;
  - WR_EN width constant (22);
  - DEMUXS encodings;
  - FSM state enum.
- Sub-module c_bus_dest_decode: combinational 5-bit code → 22-bit one-hot plus legal flag. Reused by the A-bus side for legality checks.

## Test plan
- Reset, then DEMUXS = 1, RG1_out = 5, C_BUS_in = 16'hA5A5, WR_REQ pulse → WR_EN = 22'h000020 for one cycle 2 cycles later, WR_DATA = 16'hA5A5, WR_ACK one cycle after that.
- DEMUXS = 3, RG2_out = 21, data 16'h1234; RG2_out changed to 3 during DECODE → only WR_EN[21] pulses, with data 16'h1234.
- DEMUXS = 2, MUX1D_out = 16 → WR_EN stays 0, WR_ACK pulses. ILLEGAL pulses with C_BUS_DEMUX_TRAP_EN defined and stays 0 without it.
- WR_REQ at edge 0 and again at edge 2 → a single write, OVERRUN = 1 and held until Reset.
- Reset asserted during the WRITE cycle → WR_EN drops to 0 asynchronously, no WR_ACK, BUSY = 0.
- Two requests 4 cycles apart (codes 1 and 20) → two distinct WR_EN pulses 4 cycles apart, two WR_ACK pulses, OVERRUN stays 0.

Source files
------------

// File: rtl/cbus_pkg.sv
// cbus_pkg
// Shared definitions for the C-bus write-back path: destination code
// constants, widths, DEMUXS source encodings, the demux FSM state type and a
// legality helper that the A-bus side can reuse.
// Ports: none (package).
// Optional feature macro used by c_bus_demux: C_BUS_DEMUX_TRAP_EN.
package cbus_pkg;

  localparam int DATA_W  = 16;
  localparam int CODE_W  = 5;
  localparam int WR_EN_W = 22;

  // Destination codes; the bit index in WR_EN equals the code value.
  localparam logic [CODE_W-1:0] CODE_R1   = 5'd1;
  localparam logic [CODE_W-1:0] CODE_R2   = 5'd2;
  localparam logic [CODE_W-1:0] CODE_R3   = 5'd3;
  localparam logic [CODE_W-1:0] CODE_R4   = 5'd4;
  localparam logic [CODE_W-1:0] CODE_R5   = 5'd5;
  localparam logic [CODE_W-1:0] CODE_R6   = 5'd6;
  localparam logic [CODE_W-1:0] CODE_R7   = 5'd7;
  localparam logic [CODE_W-1:0] CODE_R8   = 5'd8;
  localparam logic [CODE_W-1:0] CODE_R9   = 5'd9;
  localparam logic [CODE_W-1:0] CODE_R10  = 5'd10;
  localparam logic [CODE_W-1:0] CODE_R11  = 5'd11;
  localparam logic [CODE_W-1:0] CODE_R12  = 5'd12;
  localparam logic [CODE_W-1:0] CODE_R13  = 5'd13;
  localparam logic [CODE_W-1:0] CODE_R14  = 5'd14;
  localparam logic [CODE_W-1:0] CODE_TOTR = 5'd15;
  localparam logic [CODE_W-1:0] CODE_AR   = 5'd18;
  localparam logic [CODE_W-1:0] CODE_MDDR = 5'd19;
  localparam logic [CODE_W-1:0] CODE_AC   = 5'd20;
  localparam logic [CODE_W-1:0] CODE_MIDR = 5'd21;

  // Code that the NONE source selection resolves to; it is never legal.
  localparam logic [CODE_W-1:0] CODE_NONE = 5'd0;

  // DEMUXS source encodings.
  localparam logic [1:0] DEMUXS_NONE  = 2'd0;
  localparam logic [1:0] DEMUXS_RG1   = 2'd1;
  localparam logic [1:0] DEMUXS_MUX1D = 2'd2;
  localparam logic [1:0] DEMUXS_RG2   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WRITE,
    ST_ACK
  } cbus_state_t;

  // Legal codes form two contiguous runs: R1..TOTR and AR..MIDR.
  // Codes 16 and 17 sit in the gap and have no register behind them.
  function automatic logic code_is_legal(input logic [CODE_W-1:0] code);
    return ((code >= CODE_R1) && (code <= CODE_TOTR)) ||
           ((code >= CODE_AR) && (code <= CODE_MIDR));
  endfunction

endpackage

// File: rtl/c_bus_dest_decode.sv
// c_bus_dest_decode
// Purely combinational destination decoder: turns a 5-bit destination code
// into a one-hot register load vector plus a legal flag. Unmapped codes give
// an all-zero vector with legal low, so WR_EN bits 0, 16 and 17 never set.
// Ports:
//   code   in  5   destination code
//   onehot out 22  one-hot load vector, bit index = code
//   legal  out 1   code maps to a real register
module c_bus_dest_decode
  import cbus_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  output logic [WR_EN_W-1:0] onehot,
  output logic               legal
);

  // Each bit compares against its own index, which keeps codes 22..31
  // from ever indexing past the top of the vector.
  always_comb begin
    legal  = code_is_legal(code);
    onehot = '0;
    for (int i = 0; i < WR_EN_W; i++) begin
      onehot[i] = legal && (code == i[CODE_W-1:0]);
    end
  end

endmodule

// File: rtl/c_bus_demux.sv
// c_bus_demux
// Write-back demultiplexer for the C bus. A single-cycle WR_REQ captures the
// C-bus result and the destination code chosen by DEMUXS, then walks
// IDLE -> DECODE -> WRITE -> ACK, giving one cycle of one-hot WR_EN to the
// register bank followed by a one-cycle WR_ACK.
// Ports:
//   Clock      in  1   system clock, rising edge
//   Reset      in  1   asynchronous active-high reset
//   C_BUS_in   in  16  result data to write
//   RG1_out    in  5   destination code from RG1
//   RG2_out    in  5   destination code from RG2
//   MUX1D_out  in  5   destination code from the microinstruction field
//   DEMUXS     in  2   code source: 0 none, 1 RG1, 2 MUX1D, 3 RG2
//   WR_REQ     in  1   single-cycle write request pulse
//   WR_DATA    out 16  registered write data
//   WR_EN      out 22  one-hot load enables
//   WR_ACK     out 1   completion pulse
//   BUSY       out 1   transaction in flight
//   OVERRUN    out 1   sticky: a request was dropped
//   ILLEGAL    out 1   pulse alongside WR_ACK for an unmapped code
// Optional feature: define C_BUS_DEMUX_TRAP_EN to enable ILLEGAL; otherwise
// ILLEGAL is held at 0 and unmapped codes are acknowledged silently.
module c_bus_demux
  import cbus_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic [DATA_W-1:0]  C_BUS_in,
  input  logic [CODE_W-1:0]  RG1_out,
  input  logic [CODE_W-1:0]  RG2_out,
  input  logic [CODE_W-1:0]  MUX1D_out,
  input  logic [1:0]         DEMUXS,
  input  logic               WR_REQ,
  output logic [DATA_W-1:0]  WR_DATA,
  output logic [WR_EN_W-1:0] WR_EN,
  output logic               WR_ACK,
  output logic               BUSY,
  output logic               OVERRUN,
  output logic               ILLEGAL
);

  cbus_state_t        state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [WR_EN_W-1:0] onehot_q, onehot_d;
  logic               legal_q, legal_d;
  logic [WR_EN_W-1:0] wr_en_q, wr_en_d;
  logic               wr_ack_q, wr_ack_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               illegal_q, illegal_d;
  logic               armed_q, armed_d;

  logic [CODE_W-1:0]  sel_code;
  logic [WR_EN_W-1:0] dec_onehot;
  logic               dec_legal;

  // Source select for the destination code; only sampled on capture.
  always_comb begin
    sel_code = CODE_NONE;
    case (DEMUXS)
      DEMUXS_RG1:   sel_code = RG1_out;
      DEMUXS_MUX1D: sel_code = MUX1D_out;
      DEMUXS_RG2:   sel_code = RG2_out;
      default:      sel_code = CODE_NONE;
    endcase
  end

  // Decode from the captured code so late source changes cannot leak in.
  c_bus_dest_decode u_dest_decode (
    .code   (code_q),
    .onehot (dec_onehot),
    .legal  (dec_legal)
  );

  // Next-state and next-output logic. Outputs are computed one step ahead
  // so every port comes straight from a flop: WR_EN appears the cycle after
  // WRITE, WR_ACK the cycle after ACK. armed_q stays low for the first edge
  // after reset so a request coinciding with reset release is ignored.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    code_d    = code_q;
    onehot_d  = onehot_q;
    legal_d   = legal_q;
    overrun_d = overrun_q;
    wr_en_d   = '0;
    wr_ack_d  = 1'b0;
    illegal_d = 1'b0;
    armed_d   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (WR_REQ && armed_q) begin
          data_d  = C_BUS_in;
          code_d  = sel_code;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        onehot_d = dec_onehot;
        legal_d  = dec_legal;
        state_d  = ST_WRITE;
        if (WR_REQ) overrun_d = 1'b1;
      end
      ST_WRITE: begin
        wr_en_d = legal_q ? onehot_q : '0;
        state_d = ST_ACK;
        if (WR_REQ) overrun_d = 1'b1;
      end
      ST_ACK: begin
        wr_ack_d = 1'b1;
`ifdef C_BUS_DEMUX_TRAP_EN
        illegal_d = ~legal_q;
`else
        illegal_d = 1'b0;
`endif
        state_d = ST_IDLE;
        if (WR_REQ) overrun_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // BUSY covers the whole sequence including the cycle WR_ACK is high.
    busy_d = (state_d != ST_IDLE) || wr_ack_d;
  end

  // Single state register for the FSM and all registered outputs; reset
  // aborts any transaction in flight and zeroes every output immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      code_q    <= '0;
      onehot_q  <= '0;
      legal_q   <= 1'b0;
      wr_en_q   <= '0;
      wr_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      illegal_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      code_q    <= code_d;
      onehot_q  <= onehot_d;
      legal_q   <= legal_d;
      wr_en_q   <= wr_en_d;
      wr_ack_q  <= wr_ack_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      illegal_q <= illegal_d;
      armed_q   <= armed_d;
    end
  end

  assign WR_DATA = data_q;
  assign WR_EN   = wr_en_q;
  assign WR_ACK  = wr_ack_q;
  assign BUSY    = busy_q;
  assign OVERRUN = overrun_q;
  assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_c_bus_demux.sv
// tb_c_bus_demux
// Directed self-checking bench for c_bus_demux. Each vector carries a
// hand-computed WR_EN / WR_DATA / ILLEGAL expectation; outputs are sampled
// 1 time unit after the rising edge. Honors C_BUS_DEMUX_TRAP_EN for ILLEGAL.
module tb_c_bus_demux;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] C_BUS_in;
  logic [4:0]  RG1_out;
  logic [4:0]  RG2_out;
  logic [4:0]  MUX1D_out;
  logic [1:0]  DEMUXS;
  logic        WR_REQ;
  logic [15:0] WR_DATA;
  logic [21:0] WR_EN;
  logic        WR_ACK;
  logic        BUSY;
  logic        OVERRUN;
  logic        ILLEGAL;

  int checkCount = 0;
  int passCount  = 0;

`ifdef C_BUS_DEMUX_TRAP_EN
  localparam logic EXP_ILLEGAL = 1'b1;
`else
  localparam logic EXP_ILLEGAL = 1'b0;
`endif

  c_bus_demux dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .C_BUS_in  (C_BUS_in),
    .RG1_out   (RG1_out),
    .RG2_out   (RG2_out),
    .MUX1D_out (MUX1D_out),
    .DEMUXS    (DEMUXS),
    .WR_REQ    (WR_REQ),
    .WR_DATA   (WR_DATA),
    .WR_EN     (WR_EN),
    .WR_ACK    (WR_ACK),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN),
    .ILLEGAL   (ILLEGAL)
  );

  // 10-unit clock period
  always #5 Clock = ~Clock;

  // Hard stop in case something stalls the main sequence
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drives source codes and data, pulses WR_REQ over one edge (edge 0),
  // then scrambles the bus so a late latch would be visible.
  task automatic applyStimulus(input logic [1:0] sel, input logic [4:0] rg1,
                               input logic [4:0] rg2, input logic [4:0] mux1d,
                               input logic [15:0] data);
    DEMUXS    = sel;
    RG1_out   = rg1;
    RG2_out   = rg2;
    MUX1D_out = mux1d;
    C_BUS_in  = data;
    WR_REQ    = 1'b1;
    tick();
    WR_REQ    = 1'b0;
    C_BUS_in  = ~data;
  endtask

  // Called at edge 0 + 1; walks edges 1..4 of an isolated transaction.
  task automatic checkTransaction(input string tag, input logic [21:0] expEn,
                                  input logic [15:0] expData, input logic expIllegal);
    tick();
    checkOutput({tag, " e1 WR_EN"}, 32'(WR_EN), 32'h0);
    checkOutput({tag, " e1 BUSY"}, 32'(BUSY), 32'h1);
    tick();
    checkOutput({tag, " e2 WR_EN"}, 32'(WR_EN), 32'(expEn));
    checkOutput({tag, " e2 WR_DATA"}, 32'(WR_DATA), 32'(expData));
    checkOutput({tag, " e2 WR_ACK"}, 32'(WR_ACK), 32'h0);
    tick();
    checkOutput({tag, " e3 WR_EN"}, 32'(WR_EN), 32'h0);
    checkOutput({tag, " e3 WR_ACK"}, 32'(WR_ACK), 32'h1);
    checkOutput({tag, " e3 ILLEGAL"}, 32'(ILLEGAL), 32'(expIllegal));
    checkOutput({tag, " e3 BUSY"}, 32'(BUSY), 32'h1);
    tick();
    checkOutput({tag, " e4 WR_ACK"}, 32'(WR_ACK), 32'h0);
    checkOutput({tag, " e4 ILLEGAL"}, 32'(ILLEGAL), 32'h0);
    checkOutput({tag, " e4 BUSY"}, 32'(BUSY), 32'h0);
  endtask

  // Reset released mid-cycle, then two idle edges before any request.
  task automatic resetDut();
    WR_REQ = 1'b0;
    Reset  = 1'b1;
    repeat (2) tick();
    Reset  = 1'b0;
    repeat (2) tick();
  endtask

  // Table of extra single-source vectors: sel, mux1d/rg1 code, expected WR_EN
  logic [1:0]  tblSel  [8] = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
  logic [4:0]  tblCode [8] = '{5'd15, 5'd18, 5'd14, 5'd17, 5'd22, 5'd31, 5'd5, 5'd19};
  logic [21:0] tblEn   [8] = '{22'h008000, 22'h040000, 22'h004000, 22'h0,
                               22'h0, 22'h0, 22'h0, 22'h080000};
  logic        tblIll  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    Reset     = 1'b1;
    WR_REQ    = 1'b0;
    C_BUS_in  = 16'h0;
    RG1_out   = 5'd0;
    RG2_out   = 5'd0;
    MUX1D_out = 5'd0;
    DEMUXS    = 2'd0;
    #2;
    checkOutput("rst WR_DATA", 32'(WR_DATA), 32'h0);
    checkOutput("rst WR_EN", 32'(WR_EN), 32'h0);
    checkOutput("rst WR_ACK", 32'(WR_ACK), 32'h0);
    checkOutput("rst BUSY", 32'(BUSY), 32'h0);
    checkOutput("rst OVERRUN", 32'(OVERRUN), 32'h0);
    checkOutput("rst ILLEGAL", 32'(ILLEGAL), 32'h0);
    resetDut();

    // RG1 code 5 -> R5
    applyStimulus(2'd1, 5'd5, 5'd0, 5'd0, 16'hA5A5);
    checkOutput("t1 e0 BUSY", 32'(BUSY), 32'h1);
    checkOutput("t1 e0 WR_DATA", 32'(WR_DATA), 32'hA5A5);
    checkTransaction("t1", 22'h000020, 16'hA5A5, 1'b0);

    // RG2 code 21 -> MIDR; sources change during DECODE and must be ignored
    applyStimulus(2'd3, 5'd0, 5'd21, 5'd0, 16'h1234);
    RG2_out = 5'd3;
    DEMUXS  = 2'd1;
    RG1_out = 5'd7;
    checkTransaction("t2", 22'h200000, 16'h1234, 1'b0);

    // MUX1D code 16 is unmapped
    applyStimulus(2'd2, 5'd0, 5'd0, 5'd16, 16'hBEEF);
    checkTransaction("t3", 22'h0, 16'hBEEF, EXP_ILLEGAL);

    // Boundary codes around the legal runs, plus the NONE source
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tblSel[i], tblCode[i], 5'd0, tblCode[i], 16'(16'h0100 + i));
      checkTransaction($sformatf("tbl%0d", i), tblEn[i], 16'(16'h0100 + i),
                       tblIll[i] & EXP_ILLEGAL);
    end
    checkOutput("pre-overrun OVERRUN", 32'(OVERRUN), 32'h0);

    // Second request at edge 2 is dropped and sets OVERRUN
    applyStimulus(2'd1, 5'd9, 5'd0, 5'd0, 16'h0F0F);
    tick();
    DEMUXS   = 2'd1;
    RG1_out  = 5'd7;
    C_BUS_in = 16'h7777;
    WR_REQ   = 1'b1;
    tick();
    WR_REQ   = 1'b0;
    checkOutput("t4 e2 WR_EN", 32'(WR_EN), 32'h000200);
    checkOutput("t4 e2 WR_DATA", 32'(WR_DATA), 32'h0F0F);
    tick();
    checkOutput("t4 e3 WR_ACK", 32'(WR_ACK), 32'h1);
    checkOutput("t4 e3 OVERRUN", 32'(OVERRUN), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t4 after%0d WR_EN", i), 32'(WR_EN), 32'h0);
      checkOutput($sformatf("t4 after%0d OVERRUN", i), 32'(OVERRUN), 32'h1);
    end
    checkOutput("t4 idle BUSY", 32'(BUSY), 32'h0);
    resetDut();
    checkOutput("t4 post-reset OVERRUN", 32'(OVERRUN), 32'h0);

    // Reset during the WR_EN cycle aborts the transaction
    applyStimulus(2'd1, 5'd12, 5'd0, 5'd0, 16'hC3C3);
    tick();
    tick();
    checkOutput("t5 e2 WR_EN", 32'(WR_EN), 32'h001000);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("t5 async WR_EN", 32'(WR_EN), 32'h0);
    checkOutput("t5 async BUSY", 32'(BUSY), 32'h0);
    checkOutput("t5 async WR_DATA", 32'(WR_DATA), 32'h0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t5 after%0d WR_ACK", i), 32'(WR_ACK), 32'h0);
      checkOutput($sformatf("t5 after%0d WR_EN", i), 32'(WR_EN), 32'h0);
      checkOutput($sformatf("t5 after%0d BUSY", i), 32'(BUSY), 32'h0);
    end

    // Back-to-back: code 1 at edge 0, code 20 at edge 4
    applyStimulus(2'd1, 5'd1, 5'd0, 5'd0, 16'h1111);
    tick();
    tick();
    checkOutput("t6a e2 WR_EN", 32'(WR_EN), 32'h000002);
    checkOutput("t6a e2 WR_DATA", 32'(WR_DATA), 32'h1111);
    tick();
    checkOutput("t6a e3 WR_ACK", 32'(WR_ACK), 32'h1);
    applyStimulus(2'd1, 5'd20, 5'd0, 5'd0, 16'h2222);
    checkOutput("t6b e0 BUSY", 32'(BUSY), 32'h1);
    checkOutput("t6b e0 WR_ACK", 32'(WR_ACK), 32'h0);
    checkOutput("t6b e0 WR_DATA", 32'(WR_DATA), 32'h2222);
    checkTransaction("t6b", 22'h100000, 16'h2222, 1'b0);
    checkOutput("t6 OVERRUN", 32'(OVERRUN), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
